// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the PC sequencer: FSM state encoding, PC-source
// select codes and the default reset PC.
package pc_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_BOOT  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_DATA  = 3'd3,
    ST_TRAP  = 3'd4
  } state_e;

  localparam logic [1:0] SEL_SEQ  = 2'b00;
  localparam logic [1:0] SEL_BR   = 2'b01;
  localparam logic [1:0] SEL_JALR = 2'b10;

  localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_0000;

  localparam logic [31:0] INCR_WORD = 32'd4;
  localparam logic [31:0] INCR_HALF = 32'd2;

endpackage

// File: rtl/pc_sequencer_next_pc_calc.sv
// Next-PC mux with sequential increment and target alignment check.
// PC_SEQ_RVC_EN enables the +2 path and relaxes alignment to bit 0 only.
module pc_sequencer_next_pc_calc
  import pc_sequencer_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic [1:0]  select_i,
  input  logic [31:0] branch_pc_i,
  input  logic [31:0] jalr_pc_i,
  input  logic        is_compressed_i,
  output logic [31:0] next_pc_o,
  output logic        illegal_o
);

  logic [31:0] incr;
  logic [31:0] jalr_tgt;
  logic        br_misaligned;
  logic        jalr_misaligned;

`ifdef PC_SEQ_RVC_EN
  assign incr            = is_compressed_i ? INCR_HALF : INCR_WORD;
  assign br_misaligned   = branch_pc_i[0];
  // Bit 0 of a JALR target is always cleared, so it can never misalign here.
  assign jalr_misaligned = 1'b0;
  logic unused_bits;
  assign unused_bits = jalr_pc_i[0];
`else
  assign incr            = INCR_WORD;
  assign br_misaligned   = |branch_pc_i[1:0];
  assign jalr_misaligned = jalr_pc_i[1];
  logic unused_bits;
  assign unused_bits = jalr_pc_i[0] ^ is_compressed_i;
`endif

  assign jalr_tgt = {jalr_pc_i[31:1], 1'b0};

  always_comb begin
    next_pc_o = pc_i + incr;
    illegal_o = 1'b0;
    case (select_i)
      SEL_SEQ: begin
        next_pc_o = pc_i + incr;
      end
      SEL_BR: begin
        next_pc_o = branch_pc_i;
        illegal_o = br_misaligned;
      end
      SEL_JALR: begin
        next_pc_o = jalr_tgt;
        illegal_o = jalr_misaligned;
      end
      default: begin
        next_pc_o = pc_i;
        illegal_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle fetch/execute sequencer: owns the PC and arbitrates the unified
// memory between fetch and data access. PC_SEQ_RVC_EN enables compressed support.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = PC_RESET_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  select,
  input  logic [31:0] branch_pc,
  input  logic [31:0] jalr_pc,
  input  logic        is_compressed,
  input  logic        stall,
  input  logic        dmem_req,
  input  logic [31:0] dmem_addr,
  output logic        dmem_done,
  output logic        mem_req,
  output logic        mem_sel,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [31:0] pc,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        trap,
  output logic [2:0]  dbg_state
);

  // Memory handshake: mem_req is held with a stable mem_addr/mem_sel until
  // mem_ready is sampled high at a rising edge; that edge completes the access.

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pending_q, pending_d;

  logic [31:0] next_pc;
  logic        next_illegal;

  logic        req_c;
  logic        sel_c;
  logic [31:0] addr_c;
  logic        done_c;
  logic        valid_c;
  logic        trap_c;

  pc_sequencer_next_pc_calc u_next_pc (
    .pc_i            (pc_q),
    .select_i        (select),
    .branch_pc_i     (branch_pc),
    .jalr_pc_i       (jalr_pc),
    .is_compressed_i (is_compressed),
    .next_pc_o       (next_pc),
    .illegal_o       (next_illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_BOOT;
      pc_q      <= RESET_PC;
      instr_q   <= 32'h0;
      pending_q <= RESET_PC;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      pending_q <= pending_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    pending_d = pending_q;
    req_c     = 1'b0;
    sel_c     = 1'b0;
    addr_c    = pc_q;
    done_c    = 1'b0;
    valid_c   = 1'b0;
    trap_c    = 1'b0;
    case (state_q)
      ST_BOOT: begin
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        req_c = 1'b1;
        if (mem_ready) begin
          instr_d = mem_rdata;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        valid_c = 1'b1;
        // A stall holds the instruction even if it also wants data memory.
        if (!stall) begin
          pending_d = next_pc;
          if (next_illegal) begin
            state_d = ST_TRAP;
          end else if (dmem_req) begin
            state_d = ST_DATA;
          end else begin
            pc_d    = next_pc;
            state_d = ST_FETCH;
          end
        end
      end
      ST_DATA: begin
        req_c  = 1'b1;
        sel_c  = 1'b1;
        addr_c = dmem_addr;
        if (mem_ready) begin
          done_c  = 1'b1;
          pc_d    = pending_q;
          state_d = ST_FETCH;
        end
      end
      ST_TRAP: begin
        trap_c = 1'b1;
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  assign mem_req     = req_c;
  assign mem_sel     = sel_c;
  assign mem_addr    = addr_c;
  assign dmem_done   = done_c;
  assign instr_valid = valid_c;
  assign trap        = trap_c;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: vector table for EXEC next-PC decisions plus
// hand-written sequences for data access, stall, trap, wrap and mid-fetch reset.
module tb_pc_sequencer;
  import pc_sequencer_pkg::*;

  localparam logic [31:0] KEY = 32'h1357_9BDF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  select;
  logic [31:0] branch_pc;
  logic [31:0] jalr_pc;
  logic        is_compressed;
  logic        stall;
  logic        dmem_req;
  logic [31:0] dmem_addr;
  logic        dmem_done;
  logic        mem_req;
  logic        mem_sel;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        instr_valid;
  logic        trap;
  logic [2:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  int wait_states = 0;
  logic [3:0] wcnt;

  pc_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .select        (select),
    .branch_pc     (branch_pc),
    .jalr_pc       (jalr_pc),
    .is_compressed (is_compressed),
    .stall         (stall),
    .dmem_req      (dmem_req),
    .dmem_addr     (dmem_addr),
    .dmem_done     (dmem_done),
    .mem_req       (mem_req),
    .mem_sel       (mem_sel),
    .mem_addr      (mem_addr),
    .mem_rdata     (mem_rdata),
    .mem_ready     (mem_ready),
    .pc            (pc),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .trap          (trap),
    .dbg_state     (dbg_state)
  );

  // ---------------- clock / memory model ----------------
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) wcnt <= 4'd0;
    else if (mem_req && !mem_ready) wcnt <= wcnt + 4'd1;
    else wcnt <= 4'd0;
  end

  assign mem_ready = mem_req && (int'(wcnt) >= wait_states);
  assign mem_rdata = mem_addr ^ KEY;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required finish before 200000");
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic [1:0] sel, input logic comp, input logic [31:0] br,
                        input logic [31:0] jr, input logic dreq, input logic [31:0] daddr);
    select        = sel;
    is_compressed = comp;
    branch_pc     = br;
    jalr_pc       = jr;
    dmem_req      = dreq;
    dmem_addr     = daddr;
  endtask

  task automatic check_reset_outputs(input string tag);
    check32({tag, "_pc"},        pc,                  32'h0);
    check32({tag, "_instr"},     instr,               32'h0);
    check32({tag, "_valid"},     32'(instr_valid),    32'h0);
    check32({tag, "_mem_req"},   32'(mem_req),        32'h0);
    check32({tag, "_mem_sel"},   32'(mem_sel),        32'h0);
    check32({tag, "_mem_addr"},  mem_addr,            32'h0);
    check32({tag, "_dmem_done"}, 32'(dmem_done),      32'h0);
    check32({tag, "_trap"},      32'(trap),           32'h0);
    check32({tag, "_state"},     32'(dbg_state),      32'(ST_BOOT));
  endtask

  // Reset, then walk BOOT -> FETCH -> EXEC of the instruction at 0x0.
  task automatic reset_to_exec(input string tag, input logic full_check);
    rst_n = 1'b0;
    wait_states = 0;
    stall = 1'b0;
    set_in(SEL_SEQ, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    step();
    step();
    if (full_check) check_reset_outputs({tag, "_rst"});
    rst_n = 1'b1;
    #1;
    check32({tag, "_boot_state"}, 32'(dbg_state), 32'(ST_BOOT));
    step();
    check32({tag, "_fetch_state"}, 32'(dbg_state), 32'(ST_FETCH));
    check32({tag, "_fetch_req"}, 32'(mem_req), 32'h1);
    check32({tag, "_fetch_addr"}, mem_addr, 32'h0);
    step();
    check32({tag, "_exec_valid"}, 32'(instr_valid), 32'h1);
    check32({tag, "_exec_instr"}, instr, KEY);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [1:0]  sel;
    logic        comp;
    logic [31:0] br;
    logic [31:0] jr;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[7];
  logic [31:0] exp_q[$];

  initial begin
    int pulses;
    logic [31:0] exp_pc;

    vecs[0] = '{SEL_SEQ,  1'b0, 32'h0,   32'h0,   32'h0000_0004};
    vecs[1] = '{SEL_SEQ,  1'b0, 32'h0,   32'h0,   32'h0000_0008};
    vecs[2] = '{SEL_SEQ,  1'b0, 32'h0,   32'h0,   32'h0000_000C};
    vecs[3] = '{SEL_SEQ,  1'b0, 32'h0,   32'h0,   32'h0000_0010};
`ifdef PC_SEQ_RVC_EN
    vecs[4] = '{SEL_SEQ,  1'b1, 32'h0,   32'h0,   32'h0000_0012};
`else
    vecs[4] = '{SEL_SEQ,  1'b1, 32'h0,   32'h0,   32'h0000_0014};
`endif
    vecs[5] = '{SEL_JALR, 1'b0, 32'h0,   32'h105, 32'h0000_0104};
    vecs[6] = '{SEL_BR,   1'b0, 32'h20,  32'h0,   32'h0000_0020};

    reset_to_exec("init", 1'b1);

    // Zero-wait instructions: each one is exactly FETCH then EXEC.
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back(vecs[i].exp_pc);
      set_in(vecs[i].sel, vecs[i].comp, vecs[i].br, vecs[i].jr, 1'b0, 32'h0);
      step();
      exp_pc = exp_q.pop_front();
      check32($sformatf("vec%0d_pc", i), pc, exp_pc);
      check32($sformatf("vec%0d_fetch_addr", i), mem_addr, exp_pc);
      check32($sformatf("vec%0d_fetch_valid", i), 32'(instr_valid), 32'h0);
      check32($sformatf("vec%0d_trap", i), 32'(trap), 32'h0);
      step();
      check32($sformatf("vec%0d_instr", i), instr, exp_pc ^ KEY);
      check32($sformatf("vec%0d_exec_valid", i), 32'(instr_valid), 32'h1);
    end

    // Load at 0x20 with two wait states.
    set_in(SEL_SEQ, 1'b0, 32'h0, 32'h0, 1'b1, 32'h400);
    wait_states = 2;
    pulses = 0;
    for (int c = 0; c < 3; c++) begin
      step();
      check32($sformatf("ld_req%0d", c), 32'(mem_req), 32'h1);
      check32($sformatf("ld_sel%0d", c), 32'(mem_sel), 32'h1);
      check32($sformatf("ld_addr%0d", c), mem_addr, 32'h400);
      check32($sformatf("ld_pc%0d", c), pc, 32'h20);
      if (dmem_done) pulses++;
    end
    check32("ld_done_last", 32'(dmem_done), 32'h1);
    check32("ld_done_count", 32'(pulses), 32'h1);
    wait_states = 0;
    set_in(SEL_SEQ, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    step();
    check32("ld_next_pc", pc, 32'h24);
    check32("ld_next_done", 32'(dmem_done), 32'h0);
    check32("ld_next_sel", 32'(mem_sel), 32'h0);
    step();
    check32("ld_exec_valid", 32'(instr_valid), 32'h1);

    // Stall over a pending data request.
    set_in(SEL_SEQ, 1'b0, 32'h0, 32'h0, 1'b1, 32'h500);
    stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      check32($sformatf("stall_state%0d", c), 32'(dbg_state), 32'(ST_EXEC));
      check32($sformatf("stall_req%0d", c), 32'(mem_req), 32'h0);
      check32($sformatf("stall_valid%0d", c), 32'(instr_valid), 32'h1);
    end
    stall = 1'b0;
    step();
    check32("stall_data_state", 32'(dbg_state), 32'(ST_DATA));
    check32("stall_data_addr", mem_addr, 32'h500);
    check32("stall_data_done", 32'(dmem_done), 32'h1);
    set_in(SEL_SEQ, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    step();
    check32("stall_next_pc", pc, 32'h28);
    step();

    // Misaligned branch traps and sticks.
    set_in(SEL_BR, 1'b0, 32'h201, 32'h0, 1'b0, 32'h0);
    step();
    check32("trap_flag", 32'(trap), 32'h1);
    check32("trap_pc", pc, 32'h28);
    check32("trap_req", 32'(mem_req), 32'h0);
    set_in(SEL_SEQ, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    for (int c = 0; c < 3; c++) step();
    check32("trap_sticky", 32'(trap), 32'h1);
    check32("trap_sticky_pc", pc, 32'h28);

    // Wrap at the top of the address space, then reset mid-fetch.
    reset_to_exec("wrap", 1'b1);
    set_in(SEL_BR, 1'b0, 32'hFFFF_FFFC, 32'h0, 1'b0, 32'h0);
    step();
    check32("wrap_br_pc", pc, 32'hFFFF_FFFC);
    step();
    set_in(SEL_SEQ, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    step();
    check32("wrap_pc", pc, 32'h0);
    check32("wrap_trap", 32'(trap), 32'h0);
    step();
    set_in(SEL_BR, 1'b0, 32'h80, 32'h0, 1'b0, 32'h0);
    wait_states = 3;
    step();
    step();
    check32("midf_state", 32'(dbg_state), 32'(ST_FETCH));
    check32("midf_ready", 32'(mem_ready), 32'h0);
    check32("midf_addr", mem_addr, 32'h80);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midf");

    // Illegal select code.
    reset_to_exec("ill", 1'b0);
    set_in(2'b11, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    step();
    check32("ill_trap", 32'(trap), 32'h1);
    check32("ill_pc", pc, 32'h0);

    // JALR target with bit 1 set: legal only with compressed support.
    reset_to_exec("jr2", 1'b0);
    set_in(SEL_JALR, 1'b0, 32'h0, 32'h107, 1'b0, 32'h0);
    step();
`ifdef PC_SEQ_RVC_EN
    check32("jr2_trap", 32'(trap), 32'h0);
    check32("jr2_pc", pc, 32'h106);
`else
    check32("jr2_trap", 32'(trap), 32'h1);
    check32("jr2_pc", pc, 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
